// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch sequencer for the single-cycle MIPS core. It holds the
// program counter and fetches one word at a time from instruction memory
// over a req/ack handshake. The fetched word is registered and presented to
// the decoder until execute accepts it. On acceptance the next PC is chosen
// from the decoder's jump/branch outputs and the branch condition.
//
// Parameters:
//   RESET_PC      PC loaded on reset (MIPS text base by default)
//
// Ports:
//   clk           single clock, rising edge
//   reset_n       synchronous active-low reset
//   imem_req      fetch request to instruction memory (high throughout FETCH)
//   imem_addr     byte address of the requested word (always equals pc)
//   imem_ack      memory response, imem_rdata valid in the same cycle
//   imem_rdata    fetched instruction word
//   instruction   registered instruction word presented to the decoder
//   instr_valid   instruction is valid and awaiting acceptance
//   instr_ack     execute has completed the presented instruction
//   is_jump       decoder: J-type jump
//   is_branch     decoder: conditional branch
//   branch_taken  branch condition from the ALU/compare
//   imm16         branch offset in words
//   addr26        jump target field
//   pc            address of the presented instruction
//   pc_plus4      pc + 4 (link value), combinational from pc
//   retired       count of accepted instructions (wraps)
// ---------------------------------------------------------------------------
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic        instr_valid,
   input  logic        instr_ack,
   input  logic        is_jump,
   input  logic        is_branch,
   input  logic        branch_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] addr26,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] retired
);

   // Word alignment of the PC is guaranteed even for an unaligned parameter.
   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2
   } state_t;

   state_t      state_reg;
   state_t      state_next;

   logic [31:0] pc_reg;
   logic [31:0] pc_next;
   logic [31:0] instruction_reg;
   logic [31:0] retired_reg;
   logic        imem_req_reg;
   logic        instr_valid_reg;

   logic        fetch_done;
   logic        issue_done;
   logic [31:0] branch_offset;

   // Handshakes only count in the state that owns them; stray acks elsewhere
   // are ignored by construction.
   assign fetch_done = (state_reg == FETCH) && imem_ack;
   assign issue_done = (state_reg == ISSUE) && instr_ack;

   assign pc_plus4      = pc_reg + 32'd4;
   assign branch_offset = {{14{imm16[15]}}, imm16, 2'b00};

   // Next-PC selection: jump overrides branch, a not-taken branch falls
   // through. All additions wrap modulo 2^32.
   always_comb begin
      pc_next = pc_plus4;
      if (is_jump) begin
         pc_next = {pc_plus4[31:28], addr26, 2'b00};
      end else if (is_branch && branch_taken) begin
         pc_next = pc_plus4 + branch_offset;
      end
   end

   // Sequencer next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    state_next = FETCH;
         FETCH:   if (imem_ack)  state_next = ISSUE;
         ISSUE:   if (instr_ack) state_next = FETCH;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         pc_reg          <= RESET_PC_ALIGNED;
         instruction_reg <= 32'h0000_0000;
         retired_reg     <= 32'h0000_0000;
         imem_req_reg    <= 1'b0;
         instr_valid_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         // Request and valid are registered copies of the state they
         // belong to, so they change exactly on the state transition.
         imem_req_reg    <= (state_next == FETCH);
         instr_valid_reg <= (state_next == ISSUE);
         if (fetch_done) begin
            instruction_reg <= imem_rdata;
         end
         // Decode inputs are only sampled here, so they may glitch freely
         // while the instruction is waiting for acceptance.
         if (issue_done) begin
            pc_reg      <= pc_next;
            retired_reg <= retired_reg + 32'd1;
         end
      end
   end

   assign imem_req    = imem_req_reg;
   assign imem_addr   = pc_reg;
   assign instruction = instruction_reg;
   assign instr_valid = instr_valid_reg;
   assign pc          = pc_reg;
   assign retired     = retired_reg;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer for the single-cycle MIPS core. It drives the 32-bit `instruction` word into `control` and holds the program counter. It fetches from instruction memory over a req/ack handshake, then presents the word until execute accepts it. It computes the next PC from `control`'s decode outputs (`is_jump`, `is_branch`, `imm16`, `addr26`) and the ALU branch condition.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC value loaded on reset (MIPS text base).
- `clk`  in  1: single clock, all state updates on rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  32: byte address of requested word; always equals `pc`.
- `imem_ack`  in  1: memory response; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32: fetched instruction word.
- `instruction`  out  32: registered instruction word, to `control`.
- `instr_valid`  out  1: `instruction` is valid and awaiting acceptance.
- `instr_ack`  in  1: execute has completed the presented instruction.
- `is_jump`  in  1: from `control`; J-type target jump.
- `is_branch`  in  1: from `control`; conditional branch.
- `branch_taken`  in  1: branch condition result from the ALU/compare.
- `imm16`  in  16: branch offset, in words.
- `addr26`  in  26: jump target field.
- `pc`  out  32: address of the presented instruction.
- `pc_plus4`  out  32: `pc + 4`, used as the link value.
- `retired`  out  32: count of accepted instructions.

## Operation
- FSM states: IDLE, FETCH, ISSUE.
- IDLE is entered on reset. It holds for exactly one cycle, then goes to FETCH.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ack`=1: `instruction` <= `imem_rdata`, then go to ISSUE.
  - With no ack, stay in FETCH indefinitely, with `imem_req` held and the address stable.
- ISSUE:
  - `instr_valid`=1 and `imem_req`=0. `instruction` is held stable, and the decode inputs settle combinationally from it.
  - On `instr_ack`=1: `pc` <= next_pc, `retired` <= `retired`+1, then go to FETCH.
- next_pc priority:
  1. `is_jump`: {`pc_plus4`[31:28], `addr26`, 2'b00}.
  2. `is_branch` & `branch_taken`: `pc_plus4` + {{14{`imm16`[15]}}, `imm16`, 2'b00}.
  3. Otherwise: `pc_plus4`.
- `is_jump`=1 overrides the branch inputs.
- `is_branch`=1 with `branch_taken`=0 gives `pc_plus4`.
- All PC arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 = 32'h0000_0000 with no fault. `pc`[1:0] is always 2'b00.
- `retired` wraps 32'hFFFF_FFFF -> 0.
- `imem_ack` outside FETCH is ignored.
- `instr_ack` outside ISSUE is ignored.

## Timing
- Reset values:
  - state=IDLE, `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4
  - `instruction`=32'h0000_0000 (nop)
  - `instr_valid`=0, `imem_req`=0, `retired`=0
- Reset asserted in any state (including mid-FETCH with the request outstanding) takes effect at the next edge. An ack arriving in that same cycle is discarded.
- Minimum loop is 2 cycles per instruction: FETCH with same-cycle ack, then ISSUE with same-cycle `instr_ack`.
- First `imem_req` rises 1 cycle after reset release. Its address is `RESET_PC`.
- `instr_valid` rises the cycle after the `imem_ack` edge. It falls the cycle after the `instr_ack` edge.
- The new `pc` appears on `imem_addr` the cycle after `instr_ack`, with `imem_req`=1 in that cycle.
- The next-PC inputs are sampled only on the `instr_ack` edge. They may glitch at any other time.
- Outputs are registered, except that `pc_plus4` and `imem_addr` are combinational from `pc`.

## Test plan
- Reset release, memory acks immediately with 32'h2010FEFE:
  - cycle 1: `imem_req`=1, `imem_addr`=32'h0040_0000
  - cycle 2: `instr_valid`=1, `instruction`=32'h2010FEFE
  - `retired`=0 until ack.
- Sequential flow: 3 acks with no jump/branch -> `imem_addr` sequence 32'h00400000, 32'h00400004, 32'h00400008; `retired`=3 after the third `instr_ack`.
- Branch: `pc`=32'h0040_0010, `is_branch`=1, `imm16`=16'hFFFD.
  - `branch_taken`=1 -> next `imem_addr`=32'h0040_0008.
  - Repeat with `branch_taken`=0 -> 32'h0040_0014.
- Jump: `pc`=32'h0040_0020, `is_jump`=1, `is_branch`=1, `branch_taken`=1, `addr26`=26'h010_0005 -> next `imem_addr`=32'h0040_0014 (jump wins).
- Stalls and wrap:
  - `imem_ack` held low 5 cycles -> `imem_req` stays 1 and the address is stable.
  - `instr_ack` held low 4 cycles -> `instruction` is unchanged.
  - With `pc`=32'hFFFF_FFFC and no jump/branch -> next `imem_addr`=32'h0000_0000.
- Reset mid-FETCH: `reset_n`=0 coincident with `imem_ack`=1 -> next cycle state IDLE, `instr_valid`=0, `pc`=`RESET_PC`, `retired`=0, ack data discarded.
